// File: rtl/dcdl_lock_ctrl.sv
// dcdl_lock_ctrl
//   Lock controller and select-line decoder for a NAND-cell digitally
//   controlled delay line. A successive-approximation search finds the
//   largest code for which the phase detector asks for more delay. A
//   filtered +/-1 tracking loop then follows drift.
//
// Ports
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   en         controller enable; low sends the FSM to IDLE and holds code
//   start      one-cycle pulse that (re)starts SAR acquisition when en=1
//   pd_up      phase-detector decision, 1 = delay too short
//   code       current delay code
//   t_sel      one-hot turnaround select, bit[code] = 1
//   tb_sel     forward-pass select, bit[i] = 1 for i < code
//   busy       high during SAR acquisition
//   locked     loop locked
//   range_err  sticky: tracking tried to step past either end of the line
//   state_dbg  current FSM state (IDLE=0, SAR_WAIT=1, TRACK_WAIT=2)
//
// Control protocol: there is no valid/ready pair. start is sampled on
// every edge. A start seen with en=1 restarts acquisition from any state.
// en=0 has priority over start. pd_up is consumed only on a decision
// edge, which comes SETTLE_CYC+1 edges after the previous code update.
module dcdl_lock_ctrl #(
  parameter int  NUM_CELLS  = 32,
  parameter int  SETTLE_CYC = 4,
  parameter int  FILT_N     = 3,
  localparam int CODE_W     = $clog2(NUM_CELLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 pd_up,
  output logic [CODE_W-1:0]    code,
  output logic [NUM_CELLS-1:0] t_sel,
  output logic [NUM_CELLS-1:0] tb_sel,
  output logic                 busy,
  output logic                 locked,
  output logic                 range_err,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int FILT_W = $clog2(FILT_N + 1) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [FILT_W-1:0] FILT_POS = FILT_W'(FILT_N);
  localparam logic [FILT_W-1:0] FILT_NEG = FILT_W'(-FILT_N);
  localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(NUM_CELLS / 2);
  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SAR_WAIT   = 2'd1,
    TRACK_WAIT = 2'd2
  } state_t;

  state_t              state;
  logic [CODE_W-1:0]   trial;     // one-hot mask of the bit under trial
  logic [CNT_W-1:0]    cnt;       // settle counter
  logic [FILT_W-1:0]   filt;      // two's-complement tracking filter
  logic                last_vld;  // a tracking step has happened since start
  logic                last_up;   // direction of that step

  logic                sample;
  logic [CODE_W-1:0]   sar_code;
  logic [FILT_W-1:0]   filt_next;

  always_comb begin
    sample    = (cnt == CNT_LAST);
    // Drop the trial bit on a "too long" decision, then arm the next one.
    sar_code  = (pd_up ? code : (code & ~trial)) | (trial >> 1);
    filt_next = pd_up ? (filt + FILT_W'(1)) : (filt - FILT_W'(1));
  end

  always_comb begin
    t_sel       = '0;
    t_sel[code] = 1'b1;
    tb_sel      = t_sel - NUM_CELLS'(1);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code      <= '0;
      trial     <= '0;
      cnt       <= '0;
      filt      <= '0;
      last_vld  <= 1'b0;
      last_up   <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      range_err <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (start) begin
      state     <= SAR_WAIT;
      code      <= CODE_MID;
      trial     <= CODE_MID;
      cnt       <= '0;
      filt      <= '0;
      last_vld  <= 1'b0;
      busy      <= 1'b1;
      locked    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state)
        SAR_WAIT: begin
          if (!sample) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt   <= '0;
            code  <= sar_code;
            trial <= trial >> 1;
            if (trial[0]) begin
              state  <= TRACK_WAIT;
              filt   <= '0;
              busy   <= 1'b0;
              locked <= 1'b1;
            end
          end
        end
        TRACK_WAIT: begin
          if (!sample) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (filt_next == FILT_POS) begin
              filt <= '0;
              if (code == CODE_MAX) begin
                range_err <= 1'b1;
              end else begin
                code     <= code + CODE_W'(1);
                // Same direction twice means we are chasing, not locked.
                if (last_vld) locked <= !last_up;
                last_vld <= 1'b1;
                last_up  <= 1'b1;
              end
            end else if (filt_next == FILT_NEG) begin
              filt <= '0;
              if (code == '0) begin
                range_err <= 1'b1;
              end else begin
                code     <= code - CODE_W'(1);
                if (last_vld) locked <= last_up;
                last_vld <= 1'b1;
                last_up  <= 1'b0;
              end
            end else begin
              filt <= filt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcdl_lock_ctrl.sv
// Testbench for dcdl_lock_ctrl (NUM_CELLS=32, SETTLE_CYC=4, FILT_N=3).
// A behavioural model tracks mode, code and filter as plain integers and is
// compared against the DUT on every falling edge. Directed scenarios add
// hand-computed literal expectations.
module tb_dcdl_lock_ctrl;

  localparam int N      = 32;
  localparam int CW     = 5;
  localparam int SETTLE = 4;
  localparam int FILT   = 3;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  logic rst_n, en, start, pd_up;
  always #5 clk = ~clk;

  logic [CW-1:0] code;
  logic [N-1:0]  t_sel, tb_sel;
  logic          busy, locked, range_err;
  logic [1:0]    state_dbg;

  dcdl_lock_ctrl #(.NUM_CELLS(N), .SETTLE_CYC(SETTLE), .FILT_N(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .pd_up(pd_up),
    .code(code), .t_sel(t_sel), .tb_sel(tb_sel), .busy(busy),
    .locked(locked), .range_err(range_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int            n_chk = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 acquiring, 2 tracking
  int m_mode, m_code, m_bit, m_wait, m_filt, m_dir;
  bit m_busy, m_locked, m_rerr;

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_bit = 0; m_wait = 0; m_filt = 0; m_dir = 0;
    m_busy = 0; m_locked = 0; m_rerr = 0;
  endtask

  task automatic model_track_step(input int dir);
    if ((dir > 0 && m_code == N - 1) || (dir < 0 && m_code == 0)) begin
      m_rerr = 1;
    end else begin
      m_code += dir;
      if (m_dir == dir) m_locked = 0;
      else if (m_dir != 0) m_locked = 1;
      m_dir = dir;
    end
  endtask

  task automatic model_step();
    if (!en) begin
      m_mode = 0; m_busy = 0;
    end else if (start) begin
      m_mode = 1; m_code = N / 2; m_bit = CW - 1; m_wait = 0;
      m_locked = 0; m_rerr = 0; m_busy = 1; m_dir = 0; m_filt = 0;
    end else if (m_mode != 0) begin
      if (m_wait < SETTLE) begin
        m_wait++;
      end else begin
        m_wait = 0;
        if (m_mode == 1) begin
          if (!pd_up) m_code -= (1 << m_bit);
          if (m_bit > 0) begin
            m_bit--;
            m_code += (1 << m_bit);
          end else begin
            m_mode = 2; m_filt = 0; m_locked = 1; m_busy = 0;
          end
        end else begin
          m_filt += pd_up ? 1 : -1;
          if (m_filt == FILT) begin
            m_filt = 0; model_track_step(1);
          end else if (m_filt == -FILT) begin
            m_filt = 0; model_track_step(-1);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- phase-detector driver ----------------
  // 0: always 0, 1: always 1, 2: (code < pd_thr), 3: alternate around filter 0
  int pd_mode = 0;
  int pd_thr  = 0;

  initial begin
    pd_up = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (pd_mode)
        0:       pd_up = 1'b0;
        1:       pd_up = 1'b1;
        2:       pd_up = (m_code < pd_thr);
        default: pd_up = (m_filt <= 0);
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [63:0] one_hot;
    one_hot = 64'd1 << m_code;
    check("model code",   64'(code),      64'(m_code));
    check("model t_sel",  64'(t_sel),     one_hot);
    check("model tb_sel", 64'(tb_sel),    one_hot - 64'd1);
    check("model busy",   64'(busy),      64'(m_busy));
    check("model locked", 64'(locked),    64'(m_locked));
    check("model rerr",   64'(range_err), 64'(m_rerr));
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  // Full acquisition; expected final code comes from exp_q.
  task automatic sar_run(input int mode, input int thr);
    logic [CW-1:0] exp_code;
    pd_mode = mode;
    pd_thr  = thr;
    pulse_start();
    check("sar first code", 64'(code), 64'd16);
    check("sar busy edge0", 64'(busy), 64'd1);
    cycle(24);
    check("sar busy edge24", 64'(busy), 64'd1);
    check("sar locked edge24", 64'(locked), 64'd0);
    cycle(1);
    exp_code = exp_q.pop_front();
    check("sar final code", 64'(code), 64'(exp_code));
    check("sar busy edge25", 64'(busy), 64'd0);
    check("sar locked edge25", 64'(locked), 64'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0;
    cycle(3);
    check("reset code", 64'(code), 64'd0);
    check("reset t_sel", 64'(t_sel), 64'd1);
    check("reset tb_sel", 64'(tb_sel), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset locked", 64'(locked), 64'd0);
    check("reset rerr", 64'(range_err), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    cycle(2);

    // SAR with threshold 19: trials 16,24,20,18,19 -> 18
    exp_q.push_back(5'd18);
    sar_run(2, 19);
    check("sar18 t_sel", 64'(t_sel), 64'h40000);
    check("sar18 tb_sel", 64'(tb_sel), 64'h3FFFF);

    // Tracking from 18
    pd_mode = 1;
    cycle(14);
    check("track pre-step", 64'(code), 64'd18);
    cycle(1);
    check("track up1 code", 64'(code), 64'd19);
    check("track up1 locked", 64'(locked), 64'd1);
    cycle(15);
    check("track up2 code", 64'(code), 64'd20);
    check("track up2 locked", 64'(locked), 64'd0);
    pd_mode = 0;
    cycle(15);
    check("track down code", 64'(code), 64'd19);
    check("track down locked", 64'(locked), 64'd1);
    pd_mode = 3;
    cycle(40);
    check("track alt code", 64'(code), 64'd19);

    // Async reset mid-acquisition, between clocks
    exp_q.delete();
    pd_mode = 1;
    pulse_start();
    cycle(7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async code", 64'(code), 64'd0);
    check("async t_sel", 64'(t_sel), 64'd1);
    check("async tb_sel", 64'(tb_sel), 64'd0);
    check("async busy", 64'(busy), 64'd0);
    compare_all();
    cycle(3);
    rst_n = 1'b1;
    cycle(12);
    check("no resume code", 64'(code), 64'd0);
    check("no resume busy", 64'(busy), 64'd0);

    // SAR limits
    exp_q.push_back(5'd0);
    sar_run(0, 0);
    exp_q.push_back(5'd31);
    sar_run(1, 0);

    // Saturation at 31 with pd_up held high
    cycle(14);
    check("sat rerr early", 64'(range_err), 64'd0);
    cycle(1);
    check("sat code", 64'(code), 64'd31);
    check("sat rerr", 64'(range_err), 64'd1);
    cycle(10);

    // start during tracking restarts and clears range_err
    pulse_start();
    check("restart code", 64'(code), 64'd16);
    check("restart busy", 64'(busy), 64'd1);
    check("restart rerr", 64'(range_err), 64'd0);

    // en dropped mid-acquisition
    cycle(7);
    en = 1'b0;
    cycle(1);
    check("en off busy", 64'(busy), 64'd0);
    check("en off code", 64'(code), 64'd24);
    cycle(20);
    check("en off frozen", 64'(code), 64'd24);
    pulse_start();
    check("start ignored code", 64'(code), 64'd24);
    check("start ignored busy", 64'(busy), 64'd0);
    cycle(5);
    en = 1'b1;
    cycle(3);
    check("idle hold code", 64'(code), 64'd24);

    // One more acquisition: threshold 7 -> 6
    exp_q.push_back(5'd6);
    sar_run(2, 7);
    check("sar6 tb_sel", 64'(tb_sel), 64'h3F);
    cycle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dcdl_lock_ctrl.md
# dcdl_lock_ctrl

Lock controller and select-line decoder for a parametrised digitally controlled delay line (DCDL) built from a chain of NUM_CELLS NAND-based delay cells. The block runs a successive-approximation (SAR) search and then a filtered ±1 tracking loop, driven by a phase-detector decision. It decodes the resulting delay code into per-cell turnaround (T) and forward-pass (Tb) select lines. It sits between the phase detector and the delay chain in the DLL.

## Interface
- NUM_CELLS, 32, number of delay cells; power of two, 4..256
- CODE_W, log2(NUM_CELLS), code width (derived, not overridden)
- SETTLE_CYC, 4, wait cycles after each code change before pd_up is used (≥1)
- FILT_N, 3, tracking filter threshold (≥1)

- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  controller enable; low freezes the code and forces IDLE
- start  in  1  one-cycle pulse, begins SAR acquisition (ignored when en=0)
- pd_up  in  1  phase-detector decision; 1 = delay too short (increase code)
- code  out  CODE_W  current delay code
- t_sel  out  NUM_CELLS  one-hot turnaround select, bit[code]=1
- tb_sel  out  NUM_CELLS  forward select, bit[i]=1 for i<code
- busy  out  1  high during SAR acquisition
- locked  out  1  loop locked
- range_err  out  1  sticky: tracking hit code 0 or NUM_CELLS-1

## Operation
- States: IDLE, SAR_WAIT, TRACK_WAIT.
- IDLE: code held. If start && en, set code = NUM_CELLS/2 (trial MSB), set bit index = CODE_W-1, clear settle counter, locked and range_err, and go to SAR_WAIT.
- SAR_WAIT: count SETTLE_CYC+1 cycles, then sample pd_up.
  - If pd_up=0, clear the current trial bit.
  - If bits remain, set the next lower trial bit in the same update and restart the count.
  - After the LSB decision, go to TRACK_WAIT with the filter at 0 and locked=1.
- SAR result is the largest code for which pd_up=1; if pd_up is never 1, the result is 0.
- TRACK_WAIT: every SETTLE_CYC+1 cycles, sample pd_up.
  - The filter is a signed counter: +1 if pd_up=1, else −1.
  - At +FILT_N: code+1 and filter=0. At −FILT_N: code−1 and filter=0.
  - The counter restarts after each sample.
- Saturation: an increment at NUM_CELLS-1 or a decrement at 0 leaves code unchanged and sets range_err.
- Lock loss: two consecutive code steps in the same direction drop locked. The next step in the opposite direction re-asserts it.
- en=0 in any state: go to IDLE next edge. Code, locked and range_err are held, and busy=0.
- start && en while in SAR_WAIT or TRACK_WAIT restarts acquisition exactly as from IDLE.
- Decode is combinational from the code register: t_sel = 1<<code, tb_sel = (1<<code)-1. Exactly one t_sel bit is ever high.

## Timing
- Reset values: code=0, t_sel=…0001, tb_sel=0, busy=0, locked=0, range_err=0, state IDLE, filter=0.
- Edge 0 samples start. From edge 0 onward, code=NUM_CELLS/2 and busy=1.
- Each SAR decision lands SETTLE_CYC+1 edges after the previous code update.
- The final SAR decision is at edge CODE_W·(SETTLE_CYC+1). At that edge busy falls and locked rises.
  - Example: 32 cells, SETTLE_CYC=4 gives edge 25.
- pd_up is registered only on the decision edge. Its value in other cycles has no effect.
- Code changes at most once per SETTLE_CYC+1 cycles in every state.
- Tracking: the earliest code step is FILT_N·(SETTLE_CYC+1) cycles after SAR completion.
- Asynchronous reset mid-SAR or mid-tracking returns all outputs to reset values immediately. Nothing resumes until a new start.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-acquisition, between clocks -> all outputs are at reset values immediately, code=0, t_sel=1.
- SAR, 32 cells, SETTLE_CYC=4, pd_up=(code<19), start at edge 0 -> trial codes 16,24,20,18,19, final code=18. busy falls and locked rises at edge 25. t_sel=1<<18, tb_sel=0x3FFFF.
- SAR limits: pd_up=0 always -> code=0. pd_up=1 always -> code=31. Each completes at edge 25.
- Tracking, FILT_N=3, from code 18:
  - pd_up=1 for three samples -> code 19 after the third sample (15 cycles).
  - Three more up samples -> code 20 and locked=0.
  - Three down samples -> code 19 and locked=1.
  - Alternating up/down samples -> code never changes.
- Saturation: lock at code 31, then hold pd_up=1 -> code stays 31 and range_err=1 after the 3rd sample. A new start clears range_err.
- en/start interplay: drop en mid-SAR -> IDLE, code frozen, busy=0. start with en=0 -> ignored. start during tracking -> code=16 and busy=1 on the next edge.
